// File: rtl/tdm_slave.sv
// TDM slave: 4-slot frame, 1-bit delay after lrck rise, MSB-first W-bit samples.
// All bick-domain inputs are oversampled on clk; serial timing is derived from detected edges.
module tdm_slave #(
  parameter int W         = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bick,
  input  logic         lrck,
  input  logic         sdin,
  output logic         sdout,
  input  logic [W-1:0] sample_in0,
  input  logic [W-1:0] sample_in1,
  input  logic [W-1:0] sample_in2,
  input  logic [W-1:0] sample_in3,
  output logic [W-1:0] sample_out0,
  output logic [W-1:0] sample_out1,
  output logic [W-1:0] sample_out2,
  output logic [W-1:0] sample_out3,
  output logic         sample_valid,
  output logic         locked,
  output logic         frame_err
);
  localparam int             OW      = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam logic [OW-1:0]  OFF_MAX = OW'(SLOT_BITS - 1);
  localparam logic [31:0]    W32     = 32'(W);

  logic [1:0]          bick_q, lrck_q, sdin_q;
  logic                bick_d, lrck_prev;
  logic                started, sat;
  logic [1:0]          slot;
  logic [OW-1:0]       off;
  logic [3:0][W-1:0]   tx, rx;

  logic                bick_s, lrck_s, sdin_s;
  logic                rise, fall, fs, at_max, in_data, last_rx;
  logic [W-1:0]        tx_word, tx_sh, rx_next;

  assign bick_s  = bick_q[1];
  assign lrck_s  = lrck_q[1];
  assign sdin_s  = sdin_q[1];
  assign rise    = bick_s & ~bick_d;
  assign fall    = ~bick_s & bick_d;
  assign fs      = rise & lrck_s & ~lrck_prev;
  // slot/off together form the bit counter; at_max is count == 4*SLOT_BITS-1
  assign at_max  = (slot == 2'd3) && (off == OFF_MAX);
  assign in_data = 32'(off) < W32;
  assign last_rx = (slot == 2'd3) && (32'(off) == W32 - 32'd1);
  assign tx_word = tx[slot];
  assign tx_sh   = tx_word << off;
  assign rx_next = {rx[slot][W-2:0], sdin_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bick_q       <= '0;
      lrck_q       <= '0;
      sdin_q       <= '0;
      bick_d       <= 1'b0;
      lrck_prev    <= 1'b0;
      started      <= 1'b0;
      sat          <= 1'b0;
      slot         <= '0;
      off          <= '0;
      tx           <= '0;
      rx           <= '0;
      sdout        <= 1'b0;
      sample_out0  <= '0;
      sample_out1  <= '0;
      sample_out2  <= '0;
      sample_out3  <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      bick_q       <= {bick_q[0], bick};
      lrck_q       <= {lrck_q[0], lrck};
      sdin_q       <= {sdin_q[0], sdin};
      bick_d       <= bick_s;
      sample_valid <= 1'b0;
      if (rise) lrck_prev <= lrck_s;

      if (fs) begin
        // this edge is the delay bit; the next rising edge captures slot 0 MSB
        started <= 1'b1;
        sat     <= 1'b0;
        slot    <= '0;
        off     <= '0;
        tx      <= {sample_in3, sample_in2, sample_in1, sample_in0};
        if (started) begin
          if (at_max) begin
            locked <= 1'b1;
          end else begin
            locked    <= 1'b0;
            frame_err <= 1'b1;
          end
        end
      end else if (rise && started && !sat) begin
        if (in_data) rx[slot] <= rx_next;
        if (last_rx && locked) begin
          sample_out0  <= rx[0];
          sample_out1  <= rx[1];
          sample_out2  <= rx[2];
          sample_out3  <= rx_next;
          sample_valid <= 1'b1;
        end
        if (at_max) begin
          sat <= 1'b1;
        end else if (off == OFF_MAX) begin
          off  <= '0;
          slot <= slot + 2'd1;
        end else begin
          off <= off + 1'b1;
        end
      end

      // drive the bit that the master captures on the coming rising edge
      if (fall) sdout <= started && !sat && in_data && tx_sh[W-1];
    end
  end
endmodule

// File: doc/tdm_slave.md
TDM_SLAVE -- requirements
Module: tdm_slave

Interface
REQ-001 Parameter W, 16, sample width in bits (MSB-first, two's complement), W <= 32.
REQ-002 Parameter SLOT_BITS, 32, bick periods per TDM slot; frame = 4 slots = 4*SLOT_BITS bits (128 at default).
REQ-003 clk  input  1  system clock, clk frequency >= 8x bick frequency.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 bick  input  1  bit clock from the TDM master, asynchronous to clk.
REQ-006 lrck  input  1  frame sync from the master, rising edge marks frame start.
REQ-007 sdin  input  1  serial data from the master (master's sdin1 pin).
REQ-008 sdout  output  1  serial data to the master (master's sdout1 pin).
REQ-009 sample_in0..sample_in3  input  W each  samples to transmit in slots 0..3.
REQ-010 sample_out0..sample_out3  output  W each  samples received from slots 0..3.
REQ-011 sample_valid  output  1  one-clk strobe, sample_out* updated this cycle.
REQ-012 locked  output  1  high after one complete, error-free frame.
REQ-013 frame_err  output  1  sticky, frame start at wrong bit count.

Function
REQ-014 bick, lrck, sdin shall each pass a 2-flop synchronizer on clk; edges of bick detected from synchronized value vs. one-cycle-delayed copy.
REQ-015 On each detected bick rising edge, lrck_s and sdin_s shall be sampled; lrck sampled 1 with previous sampled lrck 0 = frame start event.
REQ-016 Frame start event bick edge is the delay bit; bit counter shall be loaded with 0 so the next rising edge captures bit 0 (slot 0 MSB).
REQ-017 Bit counter shall increment on each subsequent rising edge and saturate at 4*SLOT_BITS-1 (no wrap) until the next frame start event.
REQ-018 Bit position p: slot = p / SLOT_BITS, offset = p % SLOT_BITS; offsets 0..W-1 carry data MSB-first, offsets W..SLOT_BITS-1 ignored on receive.
REQ-019 Receive: sdin bits shall shift into a per-slot W-bit shift register; slot registers copied to sample_out* together when slot 3 offset W-1 is captured.
REQ-020 sample_valid shall pulse high exactly one clk, the cycle sample_out* update, only if locked was high before that frame started; otherwise sample_out* unchanged.
REQ-021 Transmit: sample_in0..3 shall be latched into a tx holding register on the frame start event; later changes to sample_in* do not affect the current frame.
REQ-022 sdout shall change only on detected bick falling edges, driving the bit for the position to be captured at the next rising edge: data bit at offsets 0..W-1, 0 at offsets W..SLOT_BITS-1, 0 for the delay bit and while saturated.
REQ-023 Frame start event with bit counter != 4*SLOT_BITS-1 (excluding the first frame start after reset) shall set frame_err and clear locked; the frame restarts normally.
REQ-024 locked shall set on a frame start event ending a frame with count == 4*SLOT_BITS-1 and no error; frame_err cleared only by rst.
REQ-025 Before the first frame start after reset: no capture, sdout held 0, counter idle.
REQ-026 Rising and falling bick edges cannot be detected in the same clk; simultaneous frame start and slot-3 completion cannot occur by construction.

Reset
REQ-027 rst asserted: sample_out* = 0, sample_valid = 0, sdout = 0, locked = 0, frame_err = 0, counter idle, shift/tx/sync registers = 0, immediately and independent of clk.
REQ-028 rst mid-frame: all outputs to reset values; resumes only on next frame start event.

Verification
REQ-029 Reset release, master clk 12.288 MHz-class bick/8, 3 frames, master sends slots 0x1234, 0x8000, 0x7FFF, 0xFFFF -> frame 1 no sample_valid, frames 2+ one sample_valid pulse each, sample_out0..3 = those values.
REQ-030 sample_in0..3 = 0xA5A5, 0x0001, 0x8000, 0x5A5A -> master decodes identical words, sdout 0 on offsets 16..31 and delay bit.
REQ-031 sample_in0 changed mid-frame 0x1111 -> 0x2222 -> current frame transmits 0x1111, next frame 0x2222.
REQ-032 lrck frame start injected at bit 60 -> frame_err = 1, locked = 0, next good frame sets locked = 1, frame_err stays 1.
REQ-033 lrck held low after locking -> counter saturates at 127, sdout = 0, no sample_valid beyond completed frame.
REQ-034 rst pulse at bit 40 of a frame -> all outputs 0 within the reset, no sample_valid until two further full frames.
